// File: rtl/fetch_buffer_pkg.sv
// Shared definitions for the instruction fetch slice: bus/address widths,
// the default reset PC and the canonical NOP encoding.
// Optional feature macro used by this slice: FETCH_BYPASS_EN.
package fetch_buffer_pkg;

    localparam int unsigned BUS_WIDTH        = 32;
    localparam int unsigned MEM_ADDR_W       = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

endpackage

// File: rtl/fetch_buffer_sync_fifo.sv
// Synchronous FIFO with flush, occupancy count and a registered-storage head.
// The caller guarantees that it never pushes into a full FIFO; a pop on empty
// is ignored. Reused later by the data-side store buffer.
module sync_fifo
    import fetch_buffer_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = BUS_WIDTH + MEM_ADDR_W,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    assign do_pop = pop && (count != '0);
    assign head   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush and reset both empty the FIFO.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write port; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch stage: issues sequential word fetches to a one-cycle
// instruction memory, buffers {instruction, PC} pairs in a FIFO and hands them
// to decode with valid/ready. A redirect flushes everything and restarts fetch.
// Optional feature: define FETCH_BYPASS_EN to present a return combinationally
// when the FIFO is empty (one cycle less latency).
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int unsigned        DEPTH    = 4,
    parameter int unsigned        ADDR_W   = MEM_ADDR_W,
    parameter int unsigned        DATA_W   = BUS_WIDTH,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    output logic              o_iMem_En,
    output logic [ADDR_W-1:0] o_iMem_Addr,
    input  logic [DATA_W-1:0] i_iMem_Data,
    input  logic              i_Redirect,
    input  logic [ADDR_W-1:0] i_Redirect_PC,
    output logic              o_Instr_Valid,
    output logic [DATA_W-1:0] o_Instr_Data,
    output logic [ADDR_W-1:0] o_Instr_PC,
    input  logic              i_Instr_Ready
);

    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned ENTRY_W = DATA_W + ADDR_W;

    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  inflight_pc;
    logic               inflight;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_head;
    logic [ENTRY_W-1:0] push_word;
    logic [CNT_W:0]     credit_used;
    logic               fifo_empty;
    logic               issue;
    logic               ret_valid;
    logic               push;
    logic               pop;
    logic               head_valid;
    logic [DATA_W-1:0]  head_data;
    logic [ADDR_W-1:0]  head_pc;
    logic               unused_redirect_lsbs;

    // Low PC bits are forced to zero on redirect, so they are never consumed.
    assign unused_redirect_lsbs = ^i_Redirect_PC[1:0];

    // Issue control: a fetch needs a FIFO slot reserved for its return, so
    // both buffered entries and the in-flight word consume credit.
    always_comb begin
        credit_used = {1'b0, fifo_count} + (CNT_W + 1)'(inflight);
        issue       = !i_Rst && !i_Redirect && (credit_used < (CNT_W + 1)'(DEPTH));
        ret_valid   = inflight && !i_Redirect && !i_Rst;
        fifo_empty  = (fifo_count == '0);
        push_word   = {i_iMem_Data, inflight_pc};
        o_iMem_En   = issue;
        o_iMem_Addr = i_Rst ? '0 : fetch_pc;
    end

    // Head selection, push/pop decisions and output gating.
    always_comb begin
        head_valid = !fifo_empty;
        head_data  = fifo_head[ENTRY_W-1:ADDR_W];
        head_pc    = fifo_head[ADDR_W-1:0];
        push       = ret_valid;
`ifdef FETCH_BYPASS_EN
        // Empty FIFO: the returning word is shown directly and only stored
        // if the core does not take it this cycle.
        if (fifo_empty && ret_valid) begin
            head_valid = 1'b1;
            head_data  = i_iMem_Data;
            head_pc    = inflight_pc;
            push       = !i_Instr_Ready;
        end
`endif
        pop           = !fifo_empty && i_Instr_Ready && !i_Rst;
        o_Instr_Valid = head_valid && !i_Rst;
        o_Instr_Data  = o_Instr_Valid ? head_data : '0;
        o_Instr_PC    = o_Instr_Valid ? head_pc   : '0;
    end

    // Fetch PC and in-flight tracking; reset beats redirect, redirect beats issue.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (i_Redirect) begin
            fetch_pc <= {i_Redirect_PC[ADDR_W-1:2], 2'b00};
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + ADDR_W'(4);
            end
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (i_Clk),
        .rst   (i_Rst),
        .push  (push),
        .pop   (pop),
        .flush (i_Redirect),
        .din   (push_word),
        .count (fifo_count),
        .head  (fifo_head)
    );

endmodule
